rtc_bus_ctrl: RTL
=================

# rtc_bus_ctrl

Sequencer for the multiplexed address/data parallel bus of the real-time-clock chip. It accepts one read or write request at a time from the system controller and drives the chip's CS/RD/WR/A-D strobes and the 8-bit AD bus through six fixed-length phases. Phase length is set by an internal tick divider, so bus timing is slowed to the chip's rate. The block sits between the system control FSM and the RTC pads.

## Interface
- TICK_DIV, 221: clk cycles per bus phase; must be ≥ 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, all state updated on rising clk
- req  in  1  start request, sampled only in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- addr  in  8  RTC register address; latched with req
- wdata  in  8  write data; latched with req
- ad_in  in  8  AD bus value from pads
- ad_out  out  8  AD bus value to pads
- ad_oe  out  1  pad output enable for AD
- ad_sel  out  1  A/D select: 1 = address cycle, 0 = data cycle
- cs_n, rd_n, wr_n  out  1 each  active-low chip strobes
- rdata  out  8  read result, valid from done onward until next read completes
- busy  out  1  high in every non-IDLE state
- done  out  1  one-clk pulse at end of transaction

## Operation
- Reset: cs_n=rd_n=wr_n=1, ad_sel=0, ad_oe=0, ad_out=0, rdata=0, busy=0, done=0, state IDLE, tick counter 0.
- IDLE: req=1 at an edge → latch we/addr/wdata, clear tick counter, go ADDR_SETUP.
- Each of six phases lasts exactly TICK_DIV cycles; advance when counter = TICK_DIV-1, counter wraps to 0.
- ADDR_SETUP: cs_n=0, ad_sel=1, ad_oe=1, ad_out=addr.
- ADDR_STROBE: as ADDR_SETUP plus wr_n=0.
- ADDR_HOLD: wr_n=1, address still driven.
- DATA_SETUP: ad_sel=0; write: ad_oe=1, ad_out=wdata; read: ad_oe=0.
- DATA_STROBE: write: wr_n=0; read: rd_n=0, rdata ← ad_in on final cycle of phase.
- DATA_HOLD: rd_n=wr_n=1, cs_n=0, data-phase ad_oe kept.
- DONE (1 cycle): cs_n=1, ad_oe=0, ad_sel=0, done=1, busy=1; then IDLE.
- req, addr, we, wdata changes while busy are ignored; no queuing.
- rd_n and wr_n are never low simultaneously; ad_oe=0 whenever rd_n=0.
- Synchronous reset in any state: IDLE and reset values next cycle, no done pulse, rdata cleared.

## Timing
- Accept at edge 0 → phase n (1..6) occupies cycles (n-1)·TICK_DIV+1 … n·TICK_DIV.
- done at cycle 6·TICK_DIV+1; busy high cycles 1 … 6·TICK_DIV+1; earliest next accept edge 6·TICK_DIV+2.
- Outputs are registered; strobes change only on phase boundaries.
- Counter width = clog2(TICK_DIV); no overflow beyond TICK_DIV-1.

## Configuration
- RTC_BUS_GAP_EN defined: GAP state of TICK_DIV cycles inserted after DONE, all strobes inactive, busy=1; next accept edge 7·TICK_DIV+2.
- Undefined: DONE returns straight to IDLE.

## Structure
- Package rtc_bus_pkg: state enum (IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE, GAP), NUM_PHASES=6, strobe inactive levels.
- Sub-module rtc_tick_gen: counter with synchronous clear input and tick output (counter = TICK_DIV-1), parameter TICK_DIV.

## Test plan
(TICK_DIV=4 unless stated)
- Reset held 3 cycles → all outputs at reset values, busy=0, done=0.
- Write addr=0x21 wdata=0x45 accepted at edge 0 → ad_out=0x21 with ad_sel=1 cycles 1–12, wr_n=0 cycles 5–8 and 17–20, ad_out=0x45 cycles 13–24, done=1 cycle 25 only, busy=0 cycle 26.
- Read addr=0x33, ad_in=0x5A → rd_n=0 cycles 17–20, ad_oe=0 cycles 13–25, wr_n=0 only cycles 5–8, rdata=0x5A at done (cycle 25).
- req held high, addr changed to 0x10 at cycle 10 → first transaction keeps 0x21, second accepted edge 26 with addr 0x10, ADDR_SETUP from cycle 27.
- Reset asserted cycle 18 (DATA_STROBE) → cycle 19: cs_n=rd_n=wr_n=1, ad_oe=0, busy=0, no done pulse.
- RTC_BUS_GAP_EN defined, req held high → done cycle 25, busy high through 29, second accept edge 30.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC multiplexed-bus sequencer: state encoding, pad bundle,
// and the per-state pad decode used by rtc_bus_ctrl.
package rtc_bus_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_PHASES = 6;
  localparam int unsigned STATE_W    = 4;

  // Inactive level of the active-low chip strobes (cs_n, rd_n, wr_n).
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 4'd0,
    ADDR_SETUP  = 4'd1,
    ADDR_STROBE = 4'd2,
    ADDR_HOLD   = 4'd3,
    DATA_SETUP  = 4'd4,
    DATA_STROBE = 4'd5,
    DATA_HOLD   = 4'd6,
    DONE        = 4'd7,
    GAP         = 4'd8
  } state_t;

  typedef struct packed {
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              ad_sel;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_out;
    logic              busy;
    logic              done;
  } pins_t;

  // Successor of each timed bus phase; the last phase hands over to DONE.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      ADDR_SETUP:  n = ADDR_STROBE;
      ADDR_STROBE: n = ADDR_HOLD;
      ADDR_HOLD:   n = DATA_SETUP;
      DATA_SETUP:  n = DATA_STROBE;
      DATA_STROBE: n = DATA_HOLD;
      DATA_HOLD:   n = DONE;
      default:     n = IDLE;
    endcase
    return n;
  endfunction

  // Pad levels to present while sitting in state s.
  function automatic pins_t pins_for(input state_t            s,
                                     input logic              we,
                                     input logic [DATA_W-1:0] addr,
                                     input logic [DATA_W-1:0] wdata);
    pins_t p;
    p        = '0;
    p.cs_n   = STROBE_OFF;
    p.rd_n   = STROBE_OFF;
    p.wr_n   = STROBE_OFF;
    p.busy   = (s != IDLE);
    case (s)
      ADDR_SETUP, ADDR_HOLD: begin
        p.cs_n   = STROBE_ON;
        p.ad_sel = 1'b1;
        p.ad_oe  = 1'b1;
        p.ad_out = addr;
      end
      ADDR_STROBE: begin
        p.cs_n   = STROBE_ON;
        p.wr_n   = STROBE_ON;
        p.ad_sel = 1'b1;
        p.ad_oe  = 1'b1;
        p.ad_out = addr;
      end
      DATA_SETUP, DATA_HOLD: begin
        p.cs_n   = STROBE_ON;
        p.ad_oe  = we;
        p.ad_out = we ? wdata : '0;
      end
      DATA_STROBE: begin
        p.cs_n = STROBE_ON;
        if (we) begin
          p.wr_n   = STROBE_ON;
          p.ad_oe  = 1'b1;
          p.ad_out = wdata;
        end else begin
          // Chip drives AD during a read strobe, so the pad driver stays off.
          p.rd_n = STROBE_ON;
        end
      end
      DONE: p.done = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Phase timer: counts 0..TICK_DIV-1 and flags the last cycle of each phase.
module rtc_tick_gen #(
  parameter int unsigned TICK_DIV = 221
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;

  always_comb begin
    count_nx = count + CNT_W'(1);
    if (clear || (count == LAST)) begin
      count_nx = '0;
    end
  end

  // tick is registered alongside the counter so it is high exactly while count == LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_nx;
      tick  <= (count_nx == LAST);
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Six-phase sequencer for the RTC multiplexed address/data bus.
// Optional RTC_BUS_GAP_EN inserts a TICK_DIV-cycle idle GAP after DONE.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = 221
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              ad_sel,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);

  state_t            state;
  pins_t             pins;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              tick;
  logic              tick_clear;

  // Timer restarts on accept and in DONE so each phase (and GAP) begins at count 0.
  assign tick_clear = reset || (state == IDLE) || (state == DONE);

  rtc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Pads are registered: the pad image of the state being entered loads on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pins    <= pins_for(IDLE, 1'b0, '0, '0);
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= ADDR_SETUP;
            pins    <= pins_for(ADDR_SETUP, we, addr, wdata);
          end
        end
        DONE: begin
`ifdef RTC_BUS_GAP_EN
          state <= GAP;
          pins  <= pins_for(GAP, we_q, addr_q, wdata_q);
`else
          state <= IDLE;
          pins  <= pins_for(IDLE, we_q, addr_q, wdata_q);
`endif
        end
        GAP: begin
          if (tick) begin
            state <= IDLE;
            pins  <= pins_for(IDLE, we_q, addr_q, wdata_q);
          end
        end
        default: begin
          if (tick) begin
            state <= next_phase(state);
            pins  <= pins_for(next_phase(state), we_q, addr_q, wdata_q);
          end
        end
      endcase

      // Read data is taken on the last cycle of the read strobe.
      if ((state == DATA_STROBE) && tick && !we_q) begin
        rdata <= ad_in;
      end
    end
  end

  assign cs_n   = pins.cs_n;
  assign rd_n   = pins.rd_n;
  assign wr_n   = pins.wr_n;
  assign ad_sel = pins.ad_sel;
  assign ad_oe  = pins.ad_oe;
  assign ad_out = pins.ad_out;
  assign busy   = pins.busy;
  assign done   = pins.done;

endmodule
